// File: rtl/instr_aligner.sv
// Instruction aligner: splits the word-aligned fetch stream into 16/32-bit
// RV32IC instructions. Up to three halfwords are buffered so that a 32-bit
// instruction straddling a word boundary can be reassembled. The PC of each
// emitted instruction is tracked alongside the buffer.
module instr_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fw_valid,
   output logic        fw_ready,
   input  logic [31:0] fw_data,
   output logic        ins_valid,
   input  logic        ins_ready,
   output logic [31:0] ins_data,
   output logic [31:0] ins_pc,
   output logic        ins_compressed,
   input  logic        flush,
   input  logic [31:0] flush_pc
);

   // Buffered halfwords, oldest in [15:0]; bits above hcnt halfwords are kept zero
   logic [47:0] hbuf;
   logic [1:0]  hcnt;
   logic [31:0] pc;
   logic        skip;

   logic [47:0] hbuf_nxt;
   logic [1:0]  hcnt_nxt;
   logic [31:0] pc_nxt;
   logic        skip_nxt;

   logic        is_comp;
   logic        consume;
   logic        accept;
   logic [47:0] shifted;
   logic [1:0]  cnt_left;
   logic [31:0] append;
   logic [1:0]  append_cnt;

   // Decode the oldest halfword and drive the handshake and instruction outputs
   always_comb begin
      is_comp        = (hbuf[1:0] != 2'b11);
      ins_valid      = 1'b0;
      ins_data       = 32'h0;
      ins_compressed = 1'b0;
      ins_pc         = pc;
      fw_ready       = !flush && (hcnt <= 2'd1);
      if (!flush) begin
         if (is_comp) begin
            ins_valid = (hcnt >= 2'd1);
         end else begin
            ins_valid = (hcnt >= 2'd2);
         end
      end
      if (ins_valid) begin
         ins_compressed = is_comp;
         ins_data       = is_comp ? {16'h0, hbuf[15:0]} : hbuf[31:0];
      end
   end

   // Next-state: shift out the consumed instruction, then append the accepted word; flush overrides both
   always_comb begin
      consume    = ins_valid && ins_ready;
      accept     = fw_valid && fw_ready;
      shifted    = hbuf;
      cnt_left   = hcnt;
      pc_nxt     = pc;
      skip_nxt   = skip;
      append     = fw_data;
      append_cnt = 2'd2;
      hbuf_nxt   = hbuf;
      hcnt_nxt   = hcnt;

      if (consume) begin
         if (is_comp) begin
            shifted  = {16'h0, hbuf[47:16]};
            cnt_left = hcnt - 2'd1;
            pc_nxt   = pc + 32'd2;
         end else begin
            shifted  = {32'h0, hbuf[47:32]};
            cnt_left = hcnt - 2'd2;
            pc_nxt   = pc + 32'd4;
         end
      end

      hbuf_nxt = shifted;
      hcnt_nxt = cnt_left;

      if (accept) begin
         if (skip) begin
            append     = {16'h0, fw_data[31:16]};
            append_cnt = 2'd1;
            skip_nxt   = 1'b0;
         end
         // fw_ready guarantees at most one halfword remains after the shift
         case (cnt_left)
            2'd0:    hbuf_nxt = {16'h0, append};
            2'd1:    hbuf_nxt = {append, shifted[15:0]};
            default: hbuf_nxt = shifted;
         endcase
         hcnt_nxt = cnt_left + append_cnt;
      end

      if (flush) begin
         hbuf_nxt = 48'h0;
         hcnt_nxt = 2'd0;
         pc_nxt   = {flush_pc[31:1], 1'b0};
         skip_nxt = flush_pc[1];
      end
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hbuf <= 48'h0;
         hcnt <= 2'd0;
         pc   <= RESET_PC;
         skip <= 1'b0;
      end else begin
         hbuf <= hbuf_nxt;
         hcnt <= hcnt_nxt;
         pc   <= pc_nxt;
         skip <= skip_nxt;
      end
   end

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: directed scenarios followed by a
// randomized stream, all compared against a halfword-queue reference model.
module tb_instr_aligner;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        fw_valid;
   logic        fw_ready;
   logic [31:0] fw_data;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_data;
   logic [31:0] ins_pc;
   logic        ins_compressed;
   logic        flush;
   logic [31:0] flush_pc;

   int checks   = 0;
   int failures = 0;

   // Reference model: pending halfwords of the program stream, in address order
   logic [15:0] hq[$];
   logic [31:0] mpc;
   logic        mskip;

   logic        e_valid;
   logic [31:0] e_data;
   logic        e_comp;
   logic        e_ready;

   instr_aligner #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fw_valid       (fw_valid),
      .fw_ready       (fw_ready),
      .fw_data        (fw_data),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ins_data       (ins_data),
      .ins_pc         (ins_pc),
      .ins_compressed (ins_compressed),
      .flush          (flush),
      .flush_pc       (flush_pc)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      hq.delete();
      mpc   = RESET_PC;
      mskip = 1'b0;
   endtask

   // Derive expected outputs from the pending halfwords and current inputs
   task automatic computeExpected();
      e_valid = 1'b0;
      e_data  = 32'h0;
      e_comp  = 1'b0;
      e_ready = rst_n ? (!flush && hq.size() <= 1) : 1'b1;
      if (rst_n && !flush && hq.size() >= 1) begin
         if (hq[0][1:0] != 2'b11) begin
            e_valid = 1'b1;
            e_comp  = 1'b1;
            e_data  = {16'h0, hq[0]};
         end else if (hq.size() >= 2) begin
            e_valid = 1'b1;
            e_data  = {hq[1], hq[0]};
         end
      end
   endtask

   task automatic checkAll(input string tag);
      computeExpected();
      checkOutput({tag, ".ins_valid"},      {31'h0, ins_valid},      {31'h0, e_valid});
      checkOutput({tag, ".ins_data"},       ins_data,                e_data);
      checkOutput({tag, ".ins_pc"},         ins_pc,                  mpc);
      checkOutput({tag, ".ins_compressed"}, {31'h0, ins_compressed}, {31'h0, e_comp});
      checkOutput({tag, ".fw_ready"},       {31'h0, fw_ready},       {31'h0, e_ready});
   endtask

   // Advance the model across one rising edge using the inputs presented in that cycle
   task automatic updateModel();
      if (flush) begin
         hq.delete();
         mpc   = {flush_pc[31:1], 1'b0};
         mskip = flush_pc[1];
      end else begin
         if (e_valid && ins_ready) begin
            if (e_comp) begin
               void'(hq.pop_front());
               mpc = mpc + 32'd2;
            end else begin
               void'(hq.pop_front());
               void'(hq.pop_front());
               mpc = mpc + 32'd4;
            end
         end
         if (fw_valid && e_ready) begin
            if (mskip) begin
               hq.push_back(fw_data[31:16]);
               mskip = 1'b0;
            end else begin
               hq.push_back(fw_data[15:0]);
               hq.push_back(fw_data[31:16]);
            end
         end
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then step across the rising edge
   task automatic applyStimulus(input string tag, input logic fv, input logic [31:0] fd,
                                input logic rdy, input logic fl, input logic [31:0] fpc);
      @(negedge clk);
      fw_valid  = fv;
      fw_data   = fd;
      ins_ready = rdy;
      flush     = fl;
      flush_pc  = fpc;
      #1;
      checkAll(tag);
      @(posedge clk);
      updateModel();
   endtask

   // Assert reset away from a clock edge, check the immediate effect, then release
   task automatic doReset(input string tag);
      @(negedge clk);
      fw_valid  = 1'b0;
      flush     = 1'b0;
      ins_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkAll(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      fw_valid  = 1'b0;
      fw_data   = 32'h0;
      ins_ready = 1'b0;
      flush     = 1'b0;
      flush_pc  = 32'h0;
      modelReset();
      $display("[TB] start");

      doReset("reset");

      // Single 32-bit instruction straight from reset
      applyStimulus("t1.accept", 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("t1.data_const", ins_data, 32'h0050_0093);
      checkOutput("t1.pc_const", ins_pc, 32'h0);
      applyStimulus("t1.consume", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Two compressed instructions in one word, one per cycle
      applyStimulus("t2.accept", 1'b1, 32'h0505_4501, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("t2.first_const", ins_data, 32'h0000_4501);
      applyStimulus("t2.c0", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("t2.c1", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Straddling 32-bit instruction, then a dangling low half
      applyStimulus("t3.flush", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
      applyStimulus("t3.w1", 1'b1, 32'h0093_4501, 1'b1, 1'b0, 32'h0);
      applyStimulus("t3.c", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("t3.wait", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("t3.w2", 1'b1, 32'hABCD_0050, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("t3.straddle_const", ins_data, 32'h0050_0093);
      checkOutput("t3.straddle_pc", ins_pc, 32'h2);
      applyStimulus("t3.s", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("t3.dangle", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Backpressure: ready low for five cycles while fetch keeps offering
      applyStimulus("t4.flush", 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
      for (int i = 0; i < 5; i++) begin
         applyStimulus("t4.stall", 1'b1, 32'h1111_2222 + i, 1'b0, 1'b0, 32'h0);
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus("t4.release", 1'b1, 32'h3333_4441 + i, 1'b1, 1'b0, 32'h0);
      end

      // Flush to a halfword-aligned target: lower half of the fetched word is dropped
      applyStimulus("t5.flush", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0102);
      applyStimulus("t5.word", 1'b1, 32'h0093_8001, 1'b1, 1'b0, 32'h0);
      #1;
      checkOutput("t5.pc_const", ins_pc, 32'h0000_0102);
      checkOutput("t5.wait_const", {31'h0, ins_valid}, 32'h0);
      applyStimulus("t5.word2", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h0);
      applyStimulus("t5.drain", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // PC wraparound through the top of the address space
      applyStimulus("wrap.flush", 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
      applyStimulus("wrap.w", 1'b1, 32'h0001_0001, 1'b1, 1'b0, 32'h0);
      applyStimulus("wrap.w", 1'b1, 32'h0001_0001, 1'b1, 1'b0, 32'h0);
      applyStimulus("wrap.c", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("wrap.c", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("wrap.c", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

      // Fill to three halfwords, then reset mid-stream
      applyStimulus("t6.flush", 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
      applyStimulus("t6.w1", 1'b1, 32'h0093_0001, 1'b0, 1'b0, 32'h0);
      applyStimulus("t6.c", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      applyStimulus("t6.w2", 1'b1, 32'hAAAA_0050, 1'b0, 1'b0, 32'h0);
      applyStimulus("t6.full", 1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
      doReset("t6.reset");
      applyStimulus("t6.after", 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);

      // Randomized stream with backpressure, bubbles and occasional redirects
      for (int i = 0; i < 600; i++) begin
         logic        fv;
         logic        rdy;
         logic        fl;
         logic [31:0] fd;
         logic [31:0] fpc;
         fv  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 24) == 0);
         fd  = $urandom;
         fpc = $urandom;
         applyStimulus("rand", fv, fd, rdy, fl, fpc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
